// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor controller.
package serial_sub_pkg;

    // Default operand/result width
    localparam int unsigned WIDTH_DEF = 8;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fs_bit.sv
// Combinational 1-bit full-subtractor cell: computes x - y - bi.
module fs_bit (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    // Difference is the parity of the three inputs; borrow when x < y + bi
    always_comb begin
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~x & bi) | (y & bi);
    end

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller: a - b - bin, LSB first,
// one shared fs_bit cell, valid/ready handshake on both sides.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter  int unsigned WIDTH = WIDTH_DEF,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic             brw;
    logic [CNT_W-1:0] cnt;

    logic             cell_d;
    logic             cell_bo;
    logic             last_bit;
    logic [WIDTH-1:0] d_next;

    // Single shared bit cell fed from the operand shift registers
    fs_bit u_cell (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .bi (brw),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // Final bit position and the result shift register's next value
    always_comb begin
        last_bit = (cnt == CNT_W'(WIDTH - 1));
        d_next   = {cell_d, d_sh[WIDTH-1:1]};
    end

    // Controller FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            start_ready  <= 1'b1;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            diff         <= '0;
            borrow_out   <= 1'b0;
            a_sh         <= '0;
            b_sh         <= '0;
            d_sh         <= '0;
            brw          <= 1'b0;
            cnt          <= '0;
`ifdef SERIAL_SUB_OVF_EN
            ovf          <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid && start_ready) begin
                        a_sh        <= a;
                        b_sh        <= b;
                        brw         <= bin;
                        cnt         <= '0;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end
                end

                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    d_sh <= d_next;
                    brw  <= cell_bo;
                    cnt  <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        diff         <= d_next;
                        borrow_out   <= cell_bo;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
                        // Borrow into the MSB differs from borrow out of it
                        ovf          <= brw ^ cell_bo;
`endif
                        state        <= DONE;
                    end
                end

                DONE: begin
                    // Start is only re-enabled here, so a concurrent start waits a cycle
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        start_ready  <= 1'b1;
                        state        <= IDLE;
                    end
                end

                default: begin
                    start_ready  <= 1'b1;
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (and its fs_bit cell).
module tb_serial_sub_ctrl;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         result_valid;
    logic         result_ready;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         busy;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    logic fx, fy, fbi, fd, fbo;

    int checks = 0;
    int errors = 0;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a            (a),
        .b            (b),
        .bin          (bin),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .diff         (diff),
        .borrow_out   (borrow_out),
        .busy         (busy)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf          (ovf)
`endif
    );

    fs_bit u_cell_tb (
        .x  (fx),
        .y  (fy),
        .bi (fbi),
        .d  (fd),
        .bo (fbo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Reference: plain unsigned/signed arithmetic on the whole word
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                         output logic [W-1:0] md, output logic mbo, output logic movf);
        int ua, ub, sa, sb, u, s;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        u  = ua - ub - int'(mbin);
        s  = sa - sb - int'(mbin);
        mbo  = (u < 0);
        md   = W'(u);
        movf = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
    endtask

    function automatic logic get_ovf();
`ifdef SERIAL_SUB_OVF_EN
        return ovf;
`else
        return 1'b0;
`endif
    endfunction

    // One full transaction; hold = cycles of backpressure in DONE
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                         input int hold, output logic [W-1:0] od, output logic obo,
                         output logic oovf, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!start_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_before_op", 32'(start_ready), 32'd1);
        a = ia;
        b = ib;
        bin = ibin;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        bin = 1'($urandom);
        chk("run_entry", 32'({busy, start_ready, result_valid}), 32'(3'b100));
        lat = 0;
        while (!result_valid && lat < 4 * W) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("result_valid_seen", 32'(result_valid), 32'd1);
        od = diff;
        obo = borrow_out;
        oovf = get_ovf();
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_stable", 32'({result_valid, start_ready, borrow_out, diff}),
                32'({1'b1, 1'b0, obo, od}));
        end
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        chk("retire_idle", 32'({result_valid, start_ready, busy}), 32'(3'b010));
    endtask

    typedef struct {
        logic [2:0] in;
        logic       d;
        logic       bo;
    } cell_vec_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bo;
        logic         ovf;
    } vec_t;

    cell_vec_t cvecs[8];
    vec_t      vecs[9];

    initial begin
        logic [W-1:0] od;
        logic         obo, oovf;
        logic [W-1:0] ed;
        logic         ebo, eovf;
        int           lat;
        int           n;
        logic         seen;

        // Cell truth table {x,y,bi} -> d, bo for x - y - bi
        cvecs[0] = '{3'b000, 1'b0, 1'b0};
        cvecs[1] = '{3'b001, 1'b1, 1'b1};
        cvecs[2] = '{3'b010, 1'b1, 1'b1};
        cvecs[3] = '{3'b011, 1'b0, 1'b1};
        cvecs[4] = '{3'b100, 1'b1, 1'b0};
        cvecs[5] = '{3'b101, 1'b0, 1'b0};
        cvecs[6] = '{3'b110, 1'b0, 1'b0};
        cvecs[7] = '{3'b111, 1'b1, 1'b1};

        // Directed word-level vectors
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h03, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[7] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[8] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};

        rst = 1'b1;
        start_valid = 1'b0;
        result_ready = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        fx = 1'b0;
        fy = 1'b0;
        fbi = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'({start_ready, result_valid, busy, borrow_out, diff}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
`ifdef SERIAL_SUB_OVF_EN
        chk("reset_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Standalone bit cell
        for (int i = 0; i < 8; i++) begin
            {fx, fy, fbi} = cvecs[i].in;
            #1;
            chk($sformatf("cell_%0d", i), 32'({fd, fbo}), 32'({cvecs[i].d, cvecs[i].bo}));
        end

        // Directed table, with varying backpressure (vector 1 holds 5 cycles)
        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].bin, (i == 1) ? 5 : (i % 3), od, obo, oovf, lat);
            chk($sformatf("vec%0d_diff", i), 32'(od), 32'(vecs[i].diff));
            chk($sformatf("vec%0d_borrow", i), 32'(obo), 32'(vecs[i].bo));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(W));
`ifdef SERIAL_SUB_OVF_EN
            chk($sformatf("vec%0d_ovf", i), 32'(oovf), 32'(vecs[i].ovf));
`endif
        end

        // Start requests during RUN are ignored and never queued
        @(negedge clk);
        a = 8'h11;
        b = 8'h22;
        bin = 1'b0;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hFF;
        b = 8'h00;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        n = 0;
        while (!result_valid && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
        chk("busy_rej_valid", 32'(result_valid), 32'd1);
        chk("busy_rej_diff", 32'({borrow_out, diff}), 32'({1'b1, 8'hEF}));
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2 * W + 4; i++) begin
            @(negedge clk);
            if (result_valid || busy) seen = 1'b1;
        end
        chk("busy_rej_no_second", 32'({seen, start_ready}), 32'({1'b0, 1'b1}));

        // Reset in the fourth RUN cycle aborts the operation
        @(negedge clk);
        a = 8'h5A;
        b = 8'h3C;
        bin = 1'b0;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_state", 32'({start_ready, result_valid, busy, borrow_out, diff}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (result_valid) seen = 1'b1;
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        do_op(8'h03, 8'h01, 1'b0, 0, od, obo, oovf, lat);
        chk("after_abort_diff", 32'({obo, od}), 32'({1'b0, 8'h02}));

        // Randomized operands against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic         rbin;
            ra = W'($urandom);
            rb = W'($urandom);
            rbin = 1'($urandom);
            model(ra, rb, rbin, ed, ebo, eovf);
            do_op(ra, rb, rbin, int'($urandom_range(0, 3)), od, obo, oovf, lat);
            chk($sformatf("rnd%0d_%0h_%0h_%0b", i, ra, rb, rbin), 32'({obo, od}), 32'({ebo, ed}));
            chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(W));
`ifdef SERIAL_SUB_OVF_EN
            chk($sformatf("rnd%0d_ovf", i), 32'(oovf), 32'(eovf));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
